encoder_8x3_bh: RTL and testbench
=================================

Name: encoder_8x3_bh

Overview:
- 8-input to 3-bit binary encoder with a registered output and fixed priority resolution.
- Converts an 8-bit request vector into the index of the winning set bit, plus valid and multi-hot status flags.
- Sits between request/one-hot sources (arbiter grants, interrupt lines, decoder outputs) and logic that needs a binary index one clock later.

Parameters:
- LSB_PRIORITY, 0, priority rule: 0 = highest set index wins, 1 = lowest set index wins.

Ports:
- clk    input   1  rising-edge clock.
- rst_n  input   1  reset; asynchronous assert, active low, synchronous deassert handled upstream.
- en     input   1  capture enable; when high, the output registers load the encoded i on the clk rising edge.
- i      input   8  request vector; bit k set means input k is requesting.
- y      output  3  registered binary index of the winning bit.
- valid  output  1  registered; 1 when the captured i had at least one bit set.
- multi  output  1  registered; 1 when the captured i had two or more bits set (not one-hot).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, y=3'd0, valid=0, multi=0, regardless of clk.
- Latency: one cycle. Inputs sampled at rising clk with en=1 appear on y/valid/multi immediately after that edge.
- Hold: en=0 leaves y, valid and multi unchanged.
- One-hot input 2^k (k=0..7): y=k, valid=1, multi=0.
- Multi-hot input, LSB_PRIORITY=0: y = index of the highest set bit, valid=1, multi=1.
- Multi-hot input, LSB_PRIORITY=1: y = index of the lowest set bit, valid=1, multi=1.
- i=8'h00: y=3'd0, valid=0, multi=0. Consumers must qualify y with valid.
- Reset mid-operation: outputs clear immediately on rst_n fall. The first capture after release happens on the first rising clk with rst_n=1 and en=1.
- X/Z on i: no defined output; the bench must not drive them.
- Combinational path: i to register D only. No combinational path from any input to any output.

Decomposition:
- Shared package encoder_pkg holds IN_W=8, OUT_W=3 and a function count_ge2 (popcount >= 2 test).
- Natural sub-module: encoder_8x3_core. It is purely combinational (i, LSB_PRIORITY -> idx, any, multi).
- The top instantiates the core and adds the en-gated, async-reset output registers.

Test Plan:
- Reset: hold rst_n=0 with i=8'hFF, en=1 and clk toggling -> y=0, valid=0, multi=0 throughout. Release rst_n, drive i=8'h01 -> one cycle later y=0, valid=1, multi=0.
- One-hot sweep: en=1, i = 8'h01, 02, 04, 08, 10, 20, 40, 80, each held several cycles -> y = 0, 1, 2, 3, 4, 5, 6, 7 respectively, valid=1, multi=0, each appearing one cycle after the input change.
- Priority, LSB_PRIORITY=0: i=8'b1010_0110 -> y=7, valid=1, multi=1. i=8'b0000_0011 -> y=1, multi=1.
- Priority, LSB_PRIORITY=1 (second instance): i=8'b1010_0110 -> y=1, multi=1. i=8'h80 -> y=7, multi=0.
- Zero and hold: i=8'h00, en=1 -> y=0, valid=0, multi=0. Then i=8'h10, en=1 -> y=4. Then en=0, i=8'h40 -> y stays 4 and valid stays 1 for every held cycle.
- Async reset mid-stream: y=6, valid=1, then pulse rst_n low between clock edges -> outputs clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared widths and helpers for the 8-to-3 priority encoder.
// Latency: n/a (types/functions only); backpressure: n/a.
package encoder_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  // Clearing the lowest set bit leaves something only when two or more were set.
  function automatic logic count_ge2(input logic [IN_W-1:0] v);
    return (v & (v - IN_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/encoder_8x3_bh_if.sv
// Request/result bundle for encoder_8x3_bh: master drives en/i, slave returns y/valid/multi.
// Latency: n/a (wiring only); backpressure: none, en is a plain capture strobe.
interface encoder_8x3_bh_if;
  import encoder_pkg::*;

  logic             en;
  logic [IN_W-1:0]  i;
  logic [OUT_W-1:0] y;
  logic             valid;
  logic             multi;

  modport master (output en, i, input y, valid, multi);
  modport slave  (input en, i, output y, valid, multi);

endinterface

// File: rtl/encoder_8x3_core.sv
// Combinational priority encoder: request vector -> winning index, any-set and multi-hot flags.
// Latency: zero (pure logic); backpressure: none.
module encoder_8x3_core
  import encoder_pkg::*;
#(
  parameter bit LSB_PRIORITY = 1'b0
) (
  input  logic [IN_W-1:0]  i,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  always_comb begin
    idx   = '0;
    any   = |i;
    multi = count_ge2(i);
    // Last assignment in scan order wins, so scan direction sets the priority.
    if (LSB_PRIORITY) begin
      for (int k = IN_W - 1; k >= 0; k--) begin
        if (i[k]) idx = OUT_W'(k);
      end
    end else begin
      for (int k = 0; k < IN_W; k++) begin
        if (i[k]) idx = OUT_W'(k);
      end
    end
  end

endmodule

// File: rtl/encoder_8x3_bh.sv
// Registered 8-to-3 priority encoder with valid and multi-hot status.
// Latency: 1 cycle from en=1 capture; backpressure: none, en=0 holds outputs.
module encoder_8x3_bh
  import encoder_pkg::*;
#(
  parameter bit LSB_PRIORITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  encoder_8x3_bh_if.slave  bus
);

  logic [OUT_W-1:0] idx;
  logic             any;
  logic             multi;

  logic [OUT_W-1:0] y_q;
  logic             valid_q;
  logic             multi_q;

  encoder_8x3_core #(
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_core (
    .i     (bus.i),
    .idx   (idx),
    .any   (any),
    .multi (multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else if (bus.en) begin
      y_q     <= idx;
      valid_q <= any;
      multi_q <= multi;
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.multi = multi_q;

endmodule

// File: tb/tb_encoder_8x3_bh.sv
// Scoreboard bench for encoder_8x3_bh: MSB- and LSB-priority instances driven in lockstep.
module tb_encoder_8x3_bh;
  import encoder_pkg::*;

  typedef struct packed {
    logic [2:0] y;
    logic       valid;
    logic       multi;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encoder_8x3_bh_if bus0 ();
  encoder_8x3_bh_if bus1 ();

  encoder_8x3_bh #(.LSB_PRIORITY(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  encoder_8x3_bh #(.LSB_PRIORITY(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t cur0    = '0;
  exp_t cur1    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: independent scans with early exit plus a true popcount.
  function automatic exp_t model(input logic [7:0] v, input bit lsb);
    exp_t e;
    e       = '0;
    e.valid = (v != 8'h00);
    e.multi = ($countones(v) > 1);
    if (lsb) begin
      for (int k = 0; k < 8; k++) if (v[k]) begin e.y = 3'(k); break; end
    end else begin
      for (int k = 7; k >= 0; k--) if (v[k]) begin e.y = 3'(k); break; end
    end
    return e;
  endfunction

  task automatic check_now(input string tag, input exp_t e0, input exp_t e1);
    check({tag, "_msb_y"},     32'(bus0.y),     32'(e0.y));
    check({tag, "_msb_valid"}, 32'(bus0.valid), 32'(e0.valid));
    check({tag, "_msb_multi"}, 32'(bus0.multi), 32'(e0.multi));
    check({tag, "_lsb_y"},     32'(bus1.y),     32'(e1.y));
    check({tag, "_lsb_valid"}, 32'(bus1.valid), 32'(e1.valid));
    check({tag, "_lsb_multi"}, 32'(bus1.multi), 32'(e1.multi));
  endtask

  // Called between edges; predicts the next rising edge and compares just after it.
  task automatic expect_cycle(input string tag);
    exp_t e0, e1;
    if (bus0.en) begin
      cur0 = model(bus0.i, 1'b0);
      cur1 = model(bus1.i, 1'b1);
    end
    q0.push_back(cur0);
    q1.push_back(cur1);
    @(posedge clk);
    #1;
    if (q0.size() == 0 || q1.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check_now(tag, e0, e1);
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic en_v, input logic [7:0] v);
    bus0.en = en_v; bus0.i = v;
    bus1.en = en_v; bus1.i = v;
    #1;
    // Outputs must not follow inputs before the edge.
    check_now({tag, "_pre"}, cur0, cur1);
    expect_cycle(tag);
  endtask

  initial begin
    bus0.en = 1'b1; bus0.i = 8'hFF;
    bus1.en = 1'b1; bus1.i = 8'hFF;
    rst_n   = 1'b0;

    #1;
    check_now("rst_t0", '0, '0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_now("rst_held", '0, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    step("rel_01", 1'b1, 8'h01);

    for (int k = 0; k < 8; k++) begin
      repeat (2) step("onehot", 1'b1, 8'(1 << k));
    end

    step("prio_a6", 1'b1, 8'b1010_0110);
    step("prio_03", 1'b1, 8'b0000_0011);
    step("prio_80", 1'b1, 8'h80);
    step("prio_ff", 1'b1, 8'hFF);

    step("zero", 1'b1, 8'h00);
    step("cap_10", 1'b1, 8'h10);
    repeat (3) step("hold", 1'b0, 8'h40);

    for (int n = 0; n < 6; n++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      step("rand", 1'b1, r);
    end

    step("pre_arst", 1'b1, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    cur0 = '0;
    cur1 = '0;
    check_now("arst", '0, '0);
    #1;
    rst_n = 1'b1;
    expect_cycle("post_arst");
    step("post_arst_a6", 1'b1, 8'hA6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
